// File: rtl/fb_pkg.sv
// Shared constants and types for the frame buffer write scheduler.
// Frame geometry, write record and scheduler state encoding.
package fb_pkg;

  localparam int FB_W  = 256;
  localparam int FB_H  = 240;
  localparam int PIX_W = 6;

  typedef struct packed {
    logic [7:0]       x;
    logic [7:0]       y;
    logic [PIX_W-1:0] pix;
  } fb_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  function automatic logic in_frame(input logic [7:0] x, input logic [7:0] y);
    return (int'(x) < FB_W) && (int'(y) < FB_H);
  endfunction

endpackage

// File: rtl/fb_fill_gen.sv
// Fill sweep address generator: x-inner raster counter with issue gating.
// An issue is withheld while the PPU owns the port and a fill pixel is already parked.
module fb_fill_gen
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       run,
  input  logic       hold,
  output logic       issue,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last_issue
);

  localparam logic [7:0] X_LAST = 8'(FB_W - 1);
  localparam logic [7:0] Y_LAST = 8'(FB_H - 1);

  logic swept;

  assign issue      = run && !swept && !hold;
  assign last_issue = issue && (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      x     <= '0;
      y     <= '0;
      swept <= 1'b0;
    end else if (issue) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
      if (last_issue) swept <= 1'b1;
    end
  end

endmodule

// File: rtl/fb_wr_sched.sv
// Frame buffer PPU-side write scheduler: PPU stream has priority, fill engine
// uses the idle slots through a one-entry skid register.
//
// state | meaning
// IDLE  | no fill; counters held at (0,0); waiting for start
// FILL  | sweeping addresses, issuing ROM reads / constant slots
// DRAIN | all addresses issued, flushing in-flight and skid data
module fb_wr_sched
  import fb_pkg::*;
(
  input  logic             ppu_clk,
  input  logic             rst_n,
  input  logic             ppu_valid,
  input  logic [7:0]       ppu_x,
  input  logic [7:0]       ppu_y,
  input  logic [PIX_W-1:0] ppu_pix,
  input  logic             start,
  input  logic             abort,
  input  logic             fill_mode,
  input  logic [PIX_W-1:0] fill_color,
  output logic             rom_rd,
  output logic [7:0]       rom_x,
  output logic [7:0]       rom_y,
  input  logic [PIX_W-1:0] rom_data,
  output logic             fb_we,
  output logic [7:0]       fb_x,
  output logic [7:0]       fb_y,
  output logic [PIX_W-1:0] fb_di,
  output logic             busy,
  output logic             done
);

  state_t state, state_nx;

  logic             go, kill, hold, issue, last_issue;
  logic             mode_q;
  logic [PIX_W-1:0] color_q;
  logic             inflight;
  logic [7:0]       if_x, if_y;
  logic             skid_full;
  fb_wr_t           skid, arrive, out_q;
  logic             we_q;

  assign go   = (state == IDLE) && start && !abort;
  assign kill = abort && (state != IDLE);
  assign hold = ppu_valid && (skid_full || inflight);

  fb_fill_gen u_gen (
    .clk        (ppu_clk),
    .rst_n      (rst_n),
    .clear      (state == IDLE),
    .run        (state == FILL),
    .hold       (hold),
    .issue      (issue),
    .x          (rom_x),
    .y          (rom_y),
    .last_issue (last_issue)
  );

  // Constant mode keeps the ROM idle but reuses the same one-cycle pipeline.
  assign rom_rd = issue && mode_q;
  assign arrive = {if_x, if_y, (mode_q ? rom_data : color_q)};

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:  if (go) state_nx = FILL;
      FILL: begin
        if (abort)           state_nx = IDLE;
        else if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (!skid_full && !inflight) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ppu_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge ppu_clk) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      color_q   <= '0;
      inflight  <= 1'b0;
      if_x      <= '0;
      if_y      <= '0;
      skid_full <= 1'b0;
      skid      <= '0;
      we_q      <= 1'b0;
      out_q     <= '0;
    end else begin
      if (go) begin
        mode_q  <= fill_mode;
        color_q <= fill_color;
      end
      inflight <= issue && !kill;
      if (issue) begin
        if_x <= rom_x;
        if_y <= rom_y;
      end
      we_q <= 1'b0;
      if (ppu_valid) begin
        we_q  <= in_frame(ppu_x, ppu_y);
        out_q <= {ppu_x, ppu_y, ppu_pix};
        if (inflight && !kill) begin
          skid      <= arrive;
          skid_full <= 1'b1;
        end
      end else if (skid_full && !kill) begin
        we_q      <= 1'b1;
        out_q     <= skid;
        skid_full <= 1'b0;
      end else if (inflight && !kill) begin
        we_q  <= 1'b1;
        out_q <= arrive;
      end
      if (kill) skid_full <= 1'b0;
    end
  end

  assign fb_we = we_q;
  assign fb_x  = out_q.x;
  assign fb_y  = out_q.y;
  assign fb_di = out_q.pix;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_fb_wr_sched.sv
// Scoreboard bench for fb_wr_sched: PPU writes queued at drive time, fill
// writes checked against an in-order raster model.
module tb_fb_wr_sched;
  import fb_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ppu_valid = 1'b0;
  logic [7:0]       ppu_x = '0, ppu_y = '0;
  logic [PIX_W-1:0] ppu_pix = '0;
  logic             start = 1'b0, abort = 1'b0, fill_mode = 1'b0;
  logic [PIX_W-1:0] fill_color = '0;
  logic             rom_rd;
  logic [7:0]       rom_x, rom_y;
  logic [PIX_W-1:0] rom_data = '0;
  logic             fb_we;
  logic [7:0]       fb_x, fb_y;
  logic [PIX_W-1:0] fb_di;
  logic             busy, done;

  fb_wr_sched dut (
    .ppu_clk(clk), .rst_n(rst_n), .ppu_valid(ppu_valid), .ppu_x(ppu_x),
    .ppu_y(ppu_y), .ppu_pix(ppu_pix), .start(start), .abort(abort),
    .fill_mode(fill_mode), .fill_color(fill_color), .rom_rd(rom_rd),
    .rom_x(rom_x), .rom_y(rom_y), .rom_data(rom_data), .fb_we(fb_we),
    .fb_x(fb_x), .fb_y(fb_y), .fb_di(fb_di), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] rom_pix(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] t;
    t = (x ^ y) & 8'h3F;
    return t[5:0];
  endfunction

  // ROM model: data valid only the cycle after a read, noise otherwise.
  always @(posedge clk) rom_data <= rom_rd ? rom_pix(rom_x, rom_y) : 6'($urandom);

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic        mon_en = 1'b0, exp_ppu = 1'b0, exp_drop = 1'b0;
  logic [21:0] ppu_q[$];
  int          t_start = 0, rel;
  logic [7:0]  ex = '0, ey = '0;
  int          fill_cnt = 0, done_cnt = 0, done_cyc = -1, first_cyc = -1, last_cyc = -1, rd_cnt = 0;
  logic        fill_allowed = 1'b1, exp_mode = 1'b1;
  logic [5:0]  exp_color = '0, exp_p;

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - t_start + 1;
      if (exp_ppu) begin
        chk("ppu_wr", 32'({fb_we, fb_x, fb_y, fb_di}), 32'({1'b1, ppu_q.pop_front()}));
      end else if (exp_drop) begin
        chk("ppu_drop", 32'(fb_we), 32'(1'b0));
      end else if (fb_we) begin
        exp_p = exp_mode ? rom_pix(ex, ey) : exp_color;
        chk("fill_ok", 32'(fill_allowed), 32'(1'b1));
        chk("fill_wr", 32'({fb_x, fb_y, fb_di}), 32'({ex, ey, exp_p}));
        if (fill_cnt == 0) first_cyc = rel;
        last_cyc = rel;
        fill_cnt++;
        if (ex == 8'd255) begin ex = '0; ey = ey + 8'd1; end
        else ex = ex + 8'd1;
      end
      if (done) begin done_cnt++; done_cyc = rel; end
      if (rom_rd) rd_cnt++;
      exp_ppu  = ppu_valid && in_frame(ppu_x, ppu_y);
      exp_drop = ppu_valid && !in_frame(ppu_x, ppu_y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ppu_drive(input logic [7:0] x, input logic [7:0] y, input logic [5:0] p);
    ppu_valid = 1'b1; ppu_x = x; ppu_y = y; ppu_pix = p;
    if (in_frame(x, y)) ppu_q.push_back({x, y, p});
  endtask

  task automatic ppu_rand();
    ppu_drive(8'($urandom), 8'($urandom_range(0, FB_H - 1)), 6'($urandom));
  endtask

  task automatic arm(input logic mode, input logic [5:0] color);
    fill_mode = mode; fill_color = color; exp_mode = mode; exp_color = color;
    ex = '0; ey = '0; fill_cnt = 0; done_cnt = 0; rd_cnt = 0; first_cyc = -1;
    fill_allowed = 1'b1;
    start = 1'b1; t_start = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  int lens[3] = '{1, 2, 7};
  int nb;

  initial begin
    // Reset with start and a PPU request held active.
    start = 1'b1; ppu_valid = 1'b1; ppu_x = 8'd3; ppu_y = 8'd4; ppu_pix = 6'd5;
    repeat (3) tick();
    chk("rst_out", 32'({fb_we, rom_rd, busy, done, fb_x, fb_y, fb_di}), 32'd0);
    ppu_valid = 1'b0; start = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 32'(1'b0));
    mon_en = 1'b1;

    // Uncontended ROM fill.
    arm(1'b1, 6'h00);
    chk("c1_busy", 32'(busy), 32'(1'b1));
    chk("c1_rd", 32'({rom_rd, rom_x, rom_y}), 32'({1'b1, 16'h0000}));
    for (int i = 0; i < 70000 && done_cnt == 0; i++) tick();
    chk("post_done_busy", 32'(busy), 32'(1'b0));
    repeat (3) tick();
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("done_cyc", 32'(done_cyc), 32'd61442);
    chk("first_wr_cyc", 32'(first_cyc), 32'd3);
    chk("last_wr_cyc", 32'(last_cyc), 32'd61442);
    chk("fill_total", 32'(fill_cnt), 32'd61440);

    // Contended ROM fill, then abort with the skid register occupied.
    arm(1'b1, 6'h00);
    nb = 0;
    for (int i = 0; i < 500 && fill_cnt < 990; i++) begin
      repeat ($urandom_range(3, 25)) tick();
      if (nb == 5) begin
        ppu_drive(8'd10, 8'd240, 6'h07);
        @(negedge clk);
        chk("oor_rd", 32'(rom_rd), 32'(1'b0));
        tick();
      end else begin
        for (int k = 0; k < lens[nb % 3]; k++) begin
          ppu_rand();
          tick();
        end
      end
      ppu_valid = 1'b0;
      nb++;
    end
    repeat (4) tick();
    for (int i = 0; i < 200 && fill_cnt < 1000; i++) tick();
    ppu_rand();
    tick();
    ppu_rand();
    abort = 1'b1;
    tick();
    abort = 1'b0; ppu_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'(1'b0));
    tick();
    fill_allowed = 1'b0;
    repeat (10) tick();
    chk("abort_done", 32'(done_cnt), 32'd0);
    chk("abort_ppu_q", 32'(ppu_q.size()), 32'd0);
    chk("abort_progress", 32'(fill_cnt >= 1000), 32'd1);

    // Constant-colour restart; colour input changes after start.
    arm(1'b0, 6'h2A);
    fill_color = 6'h15;
    for (int i = 0; i < 400 && fill_cnt < 3000; i++) begin
      repeat ($urandom_range(10, 40)) tick();
      repeat ($urandom_range(1, 7)) begin
        ppu_rand();
        tick();
      end
      ppu_valid = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    fill_allowed = 1'b0;
    repeat (5) tick();
    chk("const_rd", 32'(rd_cnt), 32'd0);
    chk("const_done", 32'(done_cnt), 32'd0);
    chk("const_first", 32'(first_cyc), 32'd3);
    chk("const_busy", 32'(busy), 32'(1'b0));
    chk("const_ppu_q", 32'(ppu_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
